// File: rtl/uart_tx_fifo_if.sv
// Byte/strobe handshake and status bundle between the image resizer and the UART transmitter.
interface uart_tx_fifo_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       busy;
    logic       fifo_full;
    logic       ovf_err;

    modport master (
        output trmt, tx_data,
        input  TX, tx_done, busy, fifo_full, ovf_err
    );

    modport slave (
        input  trmt, tx_data,
        output TX, tx_done, busy, fifo_full, ovf_err
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) fed by a small byte FIFO.
// Line outputs are registered from the state, so the wire trails the state machine by one clock.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    state_e            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif
    logic              tx_q, busy_q, done_q, ovf_q, stop_end_q;
    logic              full, push, pop, bit_end;

    assign full    = (count_q == DEPTH_C);
    assign push    = bus.trmt && !full;
    assign pop     = (state_q == ST_IDLE) && (count_q != '0);
    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: FIFO storage carries no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.tx_data;
    end

    // NOTE: every register below uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            stop_end_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (bus.trmt && full)  ovf_q <= 1'b1;

            case (state_q)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: tx_q <= parity_q;
`endif
                default:   tx_q <= 1'b1;
            endcase
            busy_q <= (state_q != ST_IDLE);

            // Completion is judged when the stop bit has actually left the wire.
            if (bus.trmt)        done_q <= 1'b0;
            else if (stop_end_q) done_q <= (count_q == '0);

            stop_end_q <= 1'b0;
            baud_q     <= (state_q == ST_IDLE || bit_end) ? '0 : baud_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) state_q <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state_q    <= ST_IDLE;
                        stop_end_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.TX        = tx_q;
    assign bus.tx_done   = done_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = full;
    assign bus.ovf_err   = ovf_q;
endmodule
